// File: rtl/ssd_pkg.sv
// Shared types and constants for the seven-segment scan controller.
// Cathode patterns are active-low in {a,b,c,d,e,f,g} order.
package ssd_pkg;

   typedef struct packed {
      logic       dp;
      logic [3:0] hex;
   } digit_t;

   localparam logic [7:0] SEG_OFF = 8'hFF;

   localparam logic [6:0] HEX_SEG [16] = '{
      7'b0000001,  // 0
      7'b1001111,  // 1
      7'b0010010,  // 2
      7'b0000110,  // 3
      7'b1001100,  // 4
      7'b0100100,  // 5
      7'b0100000,  // 6
      7'b0001111,  // 7
      7'b0000000,  // 8
      7'b0000100,  // 9
      7'b0001000,  // A
      7'b1100000,  // b
      7'b0110001,  // C
      7'b1000010,  // d
      7'b0110000,  // E
      7'b0111000   // F
   };

endpackage

// File: rtl/ssd_hex_decode.sv
// Combinational hex nibble to active-low seven-segment cathode decode.
module ssd_hex_decode
   import ssd_pkg::*;
(
   input  logic [3:0] hex,
   output logic [6:0] seg
);

   always_comb begin
      seg = HEX_SEG[hex];
   end

endmodule

// File: rtl/ssd_scan_ctrl.sv
// Multi-digit seven-segment scan controller with double-buffered digit file.
// Optional per-digit blinking is enabled by defining SSD_SCAN_BLINK_EN.
module ssd_scan_ctrl
   import ssd_pkg::*;
#(
   parameter int unsigned N_DIGITS = 4,
   parameter int unsigned AN_TOTAL = 8,
   parameter int unsigned SCAN_DIV = 262144,
   parameter int unsigned DEAD_CYC = 1024,
   parameter int unsigned AW       = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1
) (
   input  logic                board_clk,
   input  logic                Reset,
   input  logic                wr_en,
   input  logic [AW-1:0]       wr_addr,
   input  logic [4:0]          wr_data,
   input  logic                commit,
   input  logic [N_DIGITS-1:0] blank_mask,
`ifdef SSD_SCAN_BLINK_EN
   input  logic [N_DIGITS-1:0] blink_mask,
`endif
   output logic                commit_pending,
   output logic                frame_sync,
   output logic [AN_TOTAL-1:0] an,
   output logic [7:0]          seg
);

   localparam int unsigned   PW        = $clog2(SCAN_DIV);
   localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);
   localparam logic [PW-1:0] DEAD_END  = PW'(DEAD_CYC);
   localparam logic [AW-1:0] IDX_TOP   = AW'(N_DIGITS - 1);

   digit_t shadow_q [N_DIGITS];
   digit_t shadow_d [N_DIGITS];
   digit_t active_q [N_DIGITS];
   digit_t active_d [N_DIGITS];

   logic [PW-1:0]       presc_q, presc_d;
   logic [AW-1:0]       idx_q, idx_d;
   logic                pend_q, pend_d;
   logic                fsync_q;
   logic [AN_TOTAL-1:0] an_q, an_d;
   logic [7:0]          seg_q, seg_d;
   logic                term_cnt, frame_bnd, dark;
   logic [6:0]          dec_seg;
   digit_t              cur;

   assign term_cnt  = (presc_q == PRESC_MAX);
   assign frame_bnd = term_cnt && (idx_q == '0);
   assign cur       = active_q[idx_q];

`ifdef SSD_SCAN_BLINK_EN
   logic [5:0] frame_cnt_q;

   always_ff @(posedge board_clk or posedge Reset) begin
      if (Reset) begin
         frame_cnt_q <= '0;
      end else if (frame_bnd) begin
         frame_cnt_q <= frame_cnt_q + 6'd1;
      end
   end

   assign dark = blank_mask[idx_q] | (blink_mask[idx_q] & frame_cnt_q[5]);
`else
   assign dark = blank_mask[idx_q];
`endif

   ssd_hex_decode u_hex_decode (
      .hex (cur.hex),
      .seg (dec_seg)
   );

   always_comb begin
      presc_d = term_cnt ? '0 : presc_q + 1'b1;
      idx_d   = idx_q;
      if (term_cnt) begin
         idx_d = (idx_q == '0) ? IDX_TOP : idx_q - 1'b1;
      end
   end

   // The copy takes shadow_d so a write landing on the boundary cycle is included.
   always_comb begin
      shadow_d = shadow_q;
      if (wr_en && (32'(wr_addr) < N_DIGITS)) begin
         shadow_d[wr_addr] = wr_data;
      end
      active_d = active_q;
      if (frame_bnd && (pend_q || commit)) begin
         active_d = shadow_d;
      end
      pend_d = frame_bnd ? 1'b0 : (pend_q | commit);
   end

   always_comb begin
      an_d  = '1;
      seg_d = SEG_OFF;
      if (presc_q >= DEAD_END) begin
         seg_d = {dec_seg, ~cur.dp};
         if (!dark) begin
            an_d[idx_q] = 1'b0;
         end
      end
   end

   always_ff @(posedge board_clk or posedge Reset) begin
      if (Reset) begin
         for (int i = 0; i < int'(N_DIGITS); i++) begin
            shadow_q[i] <= '0;
            active_q[i] <= '0;
         end
         presc_q <= '0;
         idx_q   <= IDX_TOP;
         pend_q  <= 1'b0;
         fsync_q <= 1'b0;
         an_q    <= '1;
         seg_q   <= SEG_OFF;
      end else begin
         shadow_q <= shadow_d;
         active_q <= active_d;
         presc_q  <= presc_d;
         idx_q    <= idx_d;
         pend_q   <= pend_d;
         fsync_q  <= frame_bnd;
         an_q     <= an_d;
         seg_q    <= seg_d;
      end
   end

   assign commit_pending = pend_q;
   assign frame_sync     = fsync_q;
   assign an             = an_q;
   assign seg            = seg_q;

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Scoreboard bench for ssd_scan_ctrl: a 4-digit and a 3-digit instance share stimulus.
// Expected values are queued per cycle; a monitor pops and compares on falling edges.
module tb_ssd_scan_ctrl;

   logic       board_clk = 1'b0;
   logic       Reset;
   logic       wr_en = 1'b0;
   logic [1:0] wr_addr = '0;
   logic [4:0] wr_data = '0;
   logic       commit = 1'b0;
   logic [3:0] blank_mask = '0;
`ifdef SSD_SCAN_BLINK_EN
   logic [3:0] blink_mask = '0;
`endif

   logic       commit_pending, frame_sync, b_commit_pending, b_frame_sync;
   logic [7:0] an, seg, b_an, b_seg;

   always #5 board_clk = ~board_clk;

   ssd_scan_ctrl #(
      .N_DIGITS (4),
      .AN_TOTAL (8),
      .SCAN_DIV (8),
      .DEAD_CYC (2)
   ) dut (
      .board_clk      (board_clk),
      .Reset          (Reset),
      .wr_en          (wr_en),
      .wr_addr        (wr_addr),
      .wr_data        (wr_data),
      .commit         (commit),
      .blank_mask     (blank_mask),
`ifdef SSD_SCAN_BLINK_EN
      .blink_mask     (blink_mask),
`endif
      .commit_pending (commit_pending),
      .frame_sync     (frame_sync),
      .an             (an),
      .seg            (seg)
   );

   ssd_scan_ctrl #(
      .N_DIGITS (3),
      .AN_TOTAL (8),
      .SCAN_DIV (8),
      .DEAD_CYC (2)
   ) dut_b (
      .board_clk      (board_clk),
      .Reset          (Reset),
      .wr_en          (wr_en),
      .wr_addr        (wr_addr),
      .wr_data        (wr_data),
      .commit         (commit),
      .blank_mask     (3'b000),
`ifdef SSD_SCAN_BLINK_EN
      .blink_mask     (3'b000),
`endif
      .commit_pending (b_commit_pending),
      .frame_sync     (b_frame_sync),
      .an             (b_an),
      .seg            (b_seg)
   );

   typedef enum int {KAn, KSeg, KPend, KFs, KBAn, KBSeg} kind_e;
   typedef struct {
      int          cyc;
      kind_e       kind;
      logic [7:0]  val;
      string       name;
   } exp_t;

   exp_t sb[$];
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;

   // Cycle index = rising edges since the latest reset release.
   always @(posedge board_clk or posedge Reset) begin
      if (Reset) cyc <= 0;
      else       cyc <= cyc + 1;
   end

   task automatic expect_at(input int c, input kind_e k, input logic [7:0] v, input string n);
      exp_t e;
      e.cyc  = c;
      e.kind = k;
      e.val  = v;
      e.name = n;
      sb.push_back(e);
   endtask

   task automatic wait_cyc(input int n);
      while (cyc < n) @(negedge board_clk);
   endtask

   function automatic logic [7:0] pick(input kind_e k);
      case (k)
         KAn:     return an;
         KSeg:    return seg;
         KPend:   return {7'b0, commit_pending};
         KFs:     return {7'b0, frame_sync};
         KBAn:    return b_an;
         default: return b_seg;
      endcase
   endfunction

   initial begin : monitor
      exp_t       e;
      logic [7:0] act;
      forever begin
         @(negedge board_clk);
         while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            e = sb.pop_front();
            total++;
            if (e.cyc < cyc) begin
               bad++;
               $display("FAIL %s: check due at cycle %0d not reached (now %0d)", e.name, e.cyc,
                        cyc);
            end else begin
               act = pick(e.kind);
               if (act !== e.val) begin
                  bad++;
                  $display("FAIL %s: cycle %0d got %h expected %h", e.name, cyc, act, e.val);
               end
            end
         end
      end
   end

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog: time limit reached, got running expected finished");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      Reset = 1'b0;
      #1 Reset = 1'b1;
      #1;
      expect_at(0, KAn,   8'hFF, "rst_an");
      expect_at(0, KSeg,  8'hFF, "rst_seg");
      expect_at(0, KPend, 8'h00, "rst_pend");
      expect_at(0, KFs,   8'h00, "rst_fsync");
      expect_at(0, KBAn,  8'hFF, "b_rst_an");
      repeat (2) @(negedge board_clk);
      Reset = 1'b0;
      #1;

      // Scan order, dead time and frame_sync after reset.
      expect_at(1,   KAn,   8'hFF, "dead_slot0");
      expect_at(2,   KAn,   8'hFF, "dead_slot1");
      expect_at(3,   KAn,   8'hF7, "dig3_an");
      expect_at(3,   KSeg,  8'h03, "dig3_seg_zero");
      expect_at(3,   KBAn,  8'hFB, "b_dig2_an");
      expect_at(11,  KAn,   8'hFB, "dig2_an");
      expect_at(11,  KBAn,  8'hFD, "b_dig1_an");
      expect_at(19,  KAn,   8'hFD, "dig1_an");
      expect_at(19,  KBAn,  8'hFE, "b_dig0_an");
      expect_at(27,  KAn,   8'hFE, "dig0_an");
      expect_at(27,  KBAn,  8'hFB, "b_wrap_an");
      expect_at(31,  KFs,   8'h00, "fsync_pre");
      expect_at(32,  KFs,   8'h01, "fsync_pulse");
      expect_at(33,  KFs,   8'h00, "fsync_post");
      // Shadow writes and a mid-frame commit.
      expect_at(40,  KPend, 8'h00, "pend_idle");
      expect_at(42,  KPend, 8'h01, "pend_set");
      expect_at(43,  KSeg,  8'h03, "no_early_copy");
      expect_at(51,  KBSeg, 8'h49, "b_dig2_seg5");
      expect_at(59,  KBAn,  8'hFD, "b_dig1_an2");
      expect_at(59,  KBSeg, 8'h9E, "b_dig1_seg1dp");
      expect_at(63,  KPend, 8'h01, "pend_held");
      expect_at(64,  KPend, 8'h00, "pend_clear");
      expect_at(64,  KFs,   8'h01, "fsync_pulse2");
      expect_at(67,  KAn,   8'hF7, "dig3_an2");
      expect_at(67,  KSeg,  8'h11, "dig3_segA");
      expect_at(67,  KBSeg, 8'h71, "b_addr3_dropped");
      expect_at(75,  KSeg,  8'h49, "dig2_seg5");
      expect_at(83,  KAn,   8'hFD, "dig1_an2");
      expect_at(83,  KSeg,  8'h9E, "dig1_seg1dp");
      expect_at(91,  KSeg,  8'h71, "dig0_segF");
      // Commit and write on the boundary cycle itself.
      expect_at(96,  KPend, 8'h00, "bnd_pend0");
      expect_at(97,  KPend, 8'h00, "bnd_pend1");
      expect_at(99,  KBSeg, 8'h1F, "b_bnd_seg7");
      expect_at(100, KPend, 8'h00, "bnd_pend2");
      expect_at(107, KAn,   8'hFB, "bnd_dig2_an");
      expect_at(107, KSeg,  8'h1F, "bnd_dig2_seg7");
      // Blanking digit 2.
      expect_at(131, KAn,   8'hF7, "blank_dig3_lit");
      expect_at(139, KAn,   8'hFF, "blank_dig2_a");
      expect_at(139, KSeg,  8'h1F, "blank_dig2_seg");
      expect_at(141, KAn,   8'hFF, "blank_dig2_b");
      expect_at(144, KAn,   8'hFF, "blank_dig2_end");
      expect_at(147, KAn,   8'hFD, "blank_dig1_lit");
      expect_at(162, KPend, 8'h01, "pend_before_rst");

      wait_cyc(34); wr_en = 1'b1; wr_addr = 2'd2; wr_data = 5'h05;
      wait_cyc(35); wr_addr = 2'd1; wr_data = 5'h11;
      wait_cyc(36); wr_addr = 2'd0; wr_data = 5'h0F;
      wait_cyc(37); wr_addr = 2'd3; wr_data = 5'h0A;
      wait_cyc(38); wr_en = 1'b0;
      wait_cyc(40); commit = 1'b1;
      wait_cyc(41); commit = 1'b0;
      wait_cyc(95); wr_en = 1'b1; wr_addr = 2'd2; wr_data = 5'h07; commit = 1'b1;
      wait_cyc(96); wr_en = 1'b0; commit = 1'b0;
      wait_cyc(120); blank_mask = 4'b0100;
      wait_cyc(150); blank_mask = 4'b0000;
      wait_cyc(160); commit = 1'b1;
      wait_cyc(161); commit = 1'b0;
      wait_cyc(165);

      // Reset while a commit is pending.
      Reset = 1'b1;
      #1;
      expect_at(0, KPend, 8'h00, "rst2_pend");
      expect_at(0, KAn,   8'hFF, "rst2_an");
      expect_at(0, KSeg,  8'hFF, "rst2_seg");
      repeat (2) @(negedge board_clk);
      Reset = 1'b0;
`ifdef SSD_SCAN_BLINK_EN
      blink_mask = 4'b0001;
`endif
      #1;
      expect_at(3,  KAn,   8'hF7, "rst2_dig3_an");
      expect_at(3,  KSeg,  8'h03, "rst2_dig3_seg");
      expect_at(5,  KPend, 8'h00, "rst2_pend_lost");
      expect_at(11, KSeg,  8'h03, "rst2_dig2_seg");
      expect_at(19, KAn,   8'hFD, "rst2_dig1_an");
      expect_at(19, KSeg,  8'h03, "rst2_dig1_seg");
      expect_at(22, KPend, 8'h01, "rst2_pend_set");
      expect_at(32, KPend, 8'h00, "rst2_pend_clr");
      expect_at(51, KAn,   8'hFD, "rst2_shadow_an");
      expect_at(51, KSeg,  8'h03, "rst2_shadow_zero");
`ifdef SSD_SCAN_BLINK_EN
      expect_at(1019, KAn, 8'hFE, "blink_lit_f31");
      expect_at(1051, KAn, 8'hFF, "blink_dark_f32");
      expect_at(2043, KAn, 8'hFF, "blink_dark_f63");
      expect_at(2075, KAn, 8'hFE, "blink_lit_f64");
`endif
      wait_cyc(20); commit = 1'b1;
      wait_cyc(21); commit = 1'b0;
`ifdef SSD_SCAN_BLINK_EN
      wait_cyc(2080);
`else
      wait_cyc(55);
`endif
      @(negedge board_clk);
      while (sb.size() > 0) begin
         exp_t e;
         e = sb.pop_front();
         total++;
         bad++;
         $display("FAIL %s: still queued at end, got unchecked expected %h", e.name, e.val);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
